// File: rtl/parity_arb_ctrl_pkg.sv
// Shared types for the two-requester parity checker arbiter.
// Holds the FSM state encoding and the requester-id width.
package parity_arb_ctrl_pkg;

  localparam int unsigned ID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage : parity_arb_ctrl_pkg

// File: rtl/parity_arb_ctrl_parity_reduce.sv
// Combinational parity of a DW-bit word (parity bit included).
// odd = 1 when the word has an odd number of 1s; even is its complement.
module parity_reduce #(
  parameter int unsigned DW = 9
) (
  input  logic [DW-1:0] data,
  output logic          odd,
  output logic          even
);

  assign odd  = ^data;
  assign even = ~odd;

endmodule : parity_reduce

// File: rtl/parity_arb_ctrl.sv
// Round-robin share of one parity checker between two requesters, with a
// registered valid/ready result and saturating per-requester error counters.
module parity_arb_ctrl
  import parity_arb_ctrl_pkg::*;
#(
  parameter int unsigned DW         = 9,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXPECT_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [DW-1:0]    req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DW-1:0]    req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic             res_odd,
  output logic             res_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt0,
  output logic [CNT_W-1:0] err_cnt1,
  output logic             busy
);

  localparam logic EXP_ODD = (EXPECT_ODD != 0);

  state_t            state_q, state_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic [ID_W-1:0]   hold_id_q, hold_id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              res_valid_q, res_valid_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_odd_q, res_odd_d;
  logic              res_err_q, res_err_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic              chk_odd, chk_even;
  logic              chk_err;
  logic              inc0, inc1;

  parity_reduce #(.DW(DW)) u_parity_reduce (
    .data (hold_q),
    .odd  (chk_odd),
    .even (chk_even)
  );

  // A tie goes to the requester that was not granted last.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = ID_W'(0);
    if (req0_valid && req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~last_grant_q;
    end else if (req0_valid) begin
      grant_vld = 1'b1;
      grant_id  = ID_W'(0);
    end else if (req1_valid) begin
      grant_vld = 1'b1;
      grant_id  = ID_W'(1);
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && grant_vld && (grant_id == ID_W'(0));
  assign req1_ready = (state_q == ST_IDLE) && grant_vld && (grant_id == ID_W'(1));
  assign chk_err    = EXP_ODD ? chk_even : chk_odd;

  // Next-state, result and counter update.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_id_d    = hold_id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_odd_d    = res_odd_q;
    res_err_d    = res_err_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    inc0         = 1'b0;
    inc1         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          hold_d       = (grant_id == ID_W'(1)) ? req1_data : req0_data;
          hold_id_d    = grant_id;
          last_grant_d = grant_id;
          state_d      = ST_CHECK;
        end
      end
      ST_CHECK: begin
        res_odd_d   = chk_odd;
        res_err_d   = chk_err;
        res_id_d    = hold_id_q;
        res_valid_d = 1'b1;
        inc0        = chk_err && (hold_id_q == ID_W'(0));
        inc1        = chk_err && (hold_id_q == ID_W'(1));
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear has priority over a same-cycle increment; counters saturate.
    if (clr_cnt) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (inc0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + CNT_W'(1);
      if (inc1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      hold_id_q    <= ID_W'(0);
      last_grant_q <= ID_W'(1);
      res_valid_q  <= 1'b0;
      res_id_q     <= ID_W'(0);
      res_odd_q    <= 1'b0;
      res_err_q    <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_id_q    <= hold_id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_odd_q    <= res_odd_d;
      res_err_q    <= res_err_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_odd   = res_odd_q;
  assign res_err   = res_err_q;
  assign err_cnt0  = cnt0_q;
  assign err_cnt1  = cnt1_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : parity_arb_ctrl

// File: tb/tb_parity_arb_ctrl.sv
// Directed self-checking bench for parity_arb_ctrl (CNT_W=2 so saturation is reachable).
module tb_parity_arb_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [8:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       res_valid, res_ready;
  logic       res_id, res_odd, res_err;
  logic       clr_cnt;
  logic [1:0] err_cnt0, err_cnt1;
  logic       busy;

  int checks = 0;
  int errors = 0;

  parity_arb_ctrl #(.DW(9), .CNT_W(2), .EXPECT_ODD(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_odd    (res_odd),
    .res_err    (res_err),
    .clr_cnt    (clr_cnt),
    .err_cnt0   (err_cnt0),
    .err_cnt1   (err_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word, wait (bounded) for its ready, transfer it; returns in CHECK.
  task automatic send_word(input logic id, input logic [8:0] d);
    int n = 0;
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n >= 10) begin
      $display("FAIL send_word timeout: req%0d ready never seen after %0d cycles, want 1", id, n);
      errors++;
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    res_ready = 1'b0; clr_cnt = 1'b0;
    apply_reset();
    checks++;
    if ({res_valid, res_id, res_odd, res_err} !== 4'b0000) begin
      $display("FAIL reset_res: got %b want 0000", {res_valid, res_id, res_odd, res_err});
      errors++;
    end
    checks++;
    if ({err_cnt0, err_cnt1} !== 4'b0000) begin
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", err_cnt0, err_cnt1);
      errors++;
    end
    checks++;
    if ({busy, req0_ready, req1_ready} !== 3'b000) begin
      $display("FAIL reset_busy_ready: got %b want 000", {busy, req0_ready, req1_ready});
      errors++;
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 9'h003; res_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
      errors++;
    end
    step();
    req0_valid = 1'b0;
    checks++;
    if ({res_valid, busy} !== 2'b01) begin
      $display("FAIL single_check_state: valid/busy got %b want 01", {res_valid, busy});
      errors++;
    end
    step();
    checks++;
    if ({res_valid, res_odd, res_err, res_id} !== 4'b1000) begin
      $display("FAIL single_result: got %b want 1000", {res_valid, res_odd, res_err, res_id});
      errors++;
    end
    step();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      $display("FAIL single_consumed: valid/busy got %b want 00", {res_valid, busy});
      errors++;
    end
  endtask

  task automatic test_tie();
    apply_reset();
    req0_valid = 1'b1; req0_data = 9'h001;
    req1_valid = 1'b1; req1_data = 9'h007;
    res_ready = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL tie_first_grant: got %b want 10", {req0_ready, req1_ready});
      errors++;
    end
    step();
    req0_valid = 1'b0;
    step();
    checks++;
    if ({res_valid, res_id, res_odd, res_err} !== 4'b1011 || err_cnt0 !== 2'd1 || err_cnt1 !== 2'd0) begin
      $display("FAIL tie_res0: got %b cnt %0d/%0d want 1011 cnt 1/0",
               {res_valid, res_id, res_odd, res_err}, err_cnt0, err_cnt1);
      errors++;
    end
    step();
    checks++;
    if ({res_valid, req1_ready} !== 2'b01) begin
      $display("FAIL tie_second_grant: valid/ready1 got %b want 01", {res_valid, req1_ready});
      errors++;
    end
    step();
    req1_valid = 1'b0;
    step();
    checks++;
    if ({res_valid, res_id, res_odd, res_err} !== 4'b1111 || err_cnt0 !== 2'd1 || err_cnt1 !== 2'd1) begin
      $display("FAIL tie_res1: got %b cnt %0d/%0d want 1111 cnt 1/1",
               {res_valid, res_id, res_odd, res_err}, err_cnt0, err_cnt1);
      errors++;
    end
    step();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 9'h1FF;
    req1_valid = 1'b1; req1_data = 9'h000;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL bp_grant: got %b want 10", {req0_ready, req1_ready});
      errors++;
    end
    step();
    req0_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({res_valid, res_id, res_odd, res_err, req0_ready, req1_ready, busy} !== 7'b1011001
          || err_cnt0 !== 2'd2) begin
        $display("FAIL bp_hold[%0d]: got %b cnt0 %0d want 1011001 cnt0 2", i,
                 {res_valid, res_id, res_odd, res_err, req0_ready, req1_ready, busy}, err_cnt0);
        errors++;
      end
    end
    req1_valid = 1'b0;
    res_ready = 1'b1;
    step();
    checks++;
    if ({res_valid, busy} !== 2'b00) begin
      $display("FAIL bp_release: valid/busy got %b want 00", {res_valid, busy});
      errors++;
    end
    step();
    checks++;
    if ({res_valid, busy} !== 2'b00 || err_cnt0 !== 2'd2) begin
      $display("FAIL bp_single_result: valid/busy %b cnt0 %0d want 00 cnt0 2",
               {res_valid, busy}, err_cnt0);
      errors++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checks++;
    if ({err_cnt0, err_cnt1} !== 4'b0000) begin
      $display("FAIL sat_clear_idle: got %0d/%0d want 0/0", err_cnt0, err_cnt1);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
      send_word(1'b1, 9'h001);
      step();
      checks++;
      if (res_valid !== 1'b1 || err_cnt1 !== exp_cnt) begin
        $display("FAIL sat_word[%0d]: valid %b cnt1 %0d want 1 cnt1 %0d", i, res_valid, err_cnt1, exp_cnt);
        errors++;
      end
      step();
    end
    send_word(1'b1, 9'h001);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checks++;
    if (err_cnt1 !== 2'd0 || res_valid !== 1'b1 || res_err !== 1'b1) begin
      $display("FAIL sat_clear_wins: cnt1 %0d valid %b err %b want 0 1 1", err_cnt1, res_valid, res_err);
      errors++;
    end
    step();
  endtask

  task automatic test_midreset();
    send_word(1'b1, 9'h001);
    step();
    step();
    checks++;
    if (err_cnt1 !== 2'd1) begin
      $display("FAIL mid_precount: cnt1 %0d want 1", err_cnt1);
      errors++;
    end
    send_word(1'b0, 9'h001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if ({res_valid, busy} !== 2'b00 || err_cnt0 !== 2'd0 || err_cnt1 !== 2'd0) begin
      $display("FAIL mid_reset: valid/busy %b cnt %0d/%0d want 00 cnt 0/0",
               {res_valid, busy}, err_cnt0, err_cnt1);
      errors++;
    end
    req0_valid = 1'b1; req0_data = 9'h005;
    req1_valid = 1'b1; req1_data = 9'h006;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL mid_tie_grant: got %b want 10", {req0_ready, req1_ready});
      errors++;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    checks++;
    if ({res_valid, res_id, res_odd, res_err} !== 4'b1000) begin
      $display("FAIL mid_tie_result: got %b want 1000", {res_valid, res_id, res_odd, res_err});
      errors++;
    end
    step();
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_saturation();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_parity_arb_ctrl
